// File: rtl/pir_pkg.sv
// Shared constants and types for the PIR motion sampler.
package pir_pkg;
  localparam int PIR_FULL_SCALE = 100;
  localparam int PIR_SAMPLE_W   = 7;
  localparam int PIR_TP_STEP    = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_MEASURE = 3'b010,
    ST_PUBLISH = 3'b100
  } pir_state_e;

  typedef logic [PIR_SAMPLE_W-1:0] pir_sample_t;
endpackage

// File: rtl/pir_sampler_if.sv
// Detector inputs and published motion samples of pir_sampler.
interface pir_sampler_if;
  import pir_pkg::*;
  logic        enable;
  logic [2:0]  pir_raw;
  pir_sample_t pir_sensor_1;
  pir_sample_t pir_sensor_2;
  pir_sample_t pir_sensor_3;
  logic        sample_valid;
  logic [7:0]  sample_seq;

  modport master (output enable, pir_raw,
                  input  pir_sensor_1, pir_sensor_2, pir_sensor_3, sample_valid, sample_seq);
  modport slave  (input  enable, pir_raw,
                  output pir_sensor_1, pir_sensor_2, pir_sensor_3, sample_valid, sample_seq);
endinterface

// File: rtl/pir_duty_counter.sv
// One PIR channel: input synchroniser, SCALE prescaler and saturating duty counter.
module pir_duty_counter import pir_pkg::*; #(
  parameter int SCALE       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        raw,
  input  logic        clr,
  input  logic        cnt_en,
  output pir_sample_t duty
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [7:0]             pre_q;
  pir_sample_t            duty_q;
  logic                   hit;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw};

  assign hit = cnt_en && sync_q[SYNC_STAGES-1];

  // clear wins over counting so a fresh window always starts from zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre_q  <= '0;
      duty_q <= '0;
    end else if (clr) begin
      pre_q  <= '0;
      duty_q <= '0;
    end else if (hit) begin
      if (pre_q == 8'(SCALE-1)) begin
        pre_q <= '0;
        if (duty_q != pir_sample_t'(PIR_FULL_SCALE)) duty_q <= duty_q + 1'b1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end

  assign duty = duty_q;
endmodule

// File: rtl/pir_sampler.sv
// PIR front end: three-channel high-time duty over a 100*SCALE window, published with a valid strobe.
// Optional test pattern source enabled by defining PIR_SAMPLER_TESTPAT_EN.
module pir_sampler import pir_pkg::*; #(
  parameter int SCALE       = 1,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst_n,
`ifdef PIR_SAMPLER_TESTPAT_EN
  input logic test_mode,
`endif
  pir_sampler_if.slave bus
);
  localparam int WIN_LEN = PIR_FULL_SCALE * SCALE;
  localparam int WIN_W   = $clog2(WIN_LEN);

  pir_state_e        state_q, state_d;
  logic [WIN_W-1:0]  win_q;
  logic              win_last, measuring, publishing;
  pir_sample_t [2:0] duty, pub_d, pub_q;
  logic              vld_q;
  logic [7:0]        seq_q;

  assign measuring  = (state_q == ST_MEASURE);
  assign publishing = (state_q == ST_PUBLISH);
  assign win_last   = (win_q == WIN_W'(WIN_LEN-1));

  for (genvar c = 0; c < 3; c++) begin : g_ch
    pir_duty_counter #(.SCALE(SCALE), .SYNC_STAGES(SYNC_STAGES)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (bus.pir_raw[c]),
      .clr    (!measuring),
      .cnt_en (measuring),
      .duty   (duty[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.enable) state_d = ST_MEASURE;
      ST_MEASURE: if (!bus.enable) state_d = ST_IDLE;
                  else if (win_last) state_d = ST_PUBLISH;
      ST_PUBLISH: state_d = bus.enable ? ST_MEASURE : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                               win_q <= '0;
    else if (measuring && bus.enable && !win_last) win_q <= win_q + 1'b1;
    else                                      win_q <= '0;

`ifdef PIR_SAMPLER_TESTPAT_EN
  pir_sample_t tp_q;

  // pattern steps on every publish, whether or not it is being shown
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tp_q <= '0;
    else if (publishing)
      tp_q <= (tp_q == pir_sample_t'(PIR_FULL_SCALE)) ? '0 : tp_q + pir_sample_t'(PIR_TP_STEP);
`endif

  always_comb begin
    pub_d = duty;
`ifdef PIR_SAMPLER_TESTPAT_EN
    if (test_mode) begin
      pub_d[0] = tp_q;
      pub_d[1] = pir_sample_t'(PIR_FULL_SCALE) - tp_q;
      pub_d[2] = (tp_q >= pir_sample_t'(PIR_FULL_SCALE/2)) ? pir_sample_t'(PIR_FULL_SCALE) : '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pub_q <= '0;
      vld_q <= 1'b0;
      seq_q <= '0;
    end else begin
      vld_q <= publishing;
      if (publishing) begin
        pub_q <= pub_d;
        seq_q <= seq_q + 1'b1;
      end
    end

  assign bus.pir_sensor_1 = pub_q[0];
  assign bus.pir_sensor_2 = pub_q[1];
  assign bus.pir_sensor_3 = pub_q[2];
  assign bus.sample_valid = vld_q;
  assign bus.sample_seq   = seq_q;
endmodule

// File: tb/tb_pir_sampler.sv
// Self-checking bench for pir_sampler: SCALE=1 and SCALE=2 instances against a window-level duty model.
module tb_pir_sampler;
  import pir_pkg::*;

  localparam int SYNC = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pir_sampler_if bus_a();
  pir_sampler_if bus_b();

`ifdef PIR_SAMPLER_TESTPAT_EN
  logic test_mode = 1'b0;
`endif

  pir_sampler #(.SCALE(1), .SYNC_STAGES(SYNC)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
`ifdef PIR_SAMPLER_TESTPAT_EN
    .test_mode(test_mode),
`endif
    .bus(bus_a));

  pir_sampler #(.SCALE(2), .SYNC_STAGES(SYNC)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
`ifdef PIR_SAMPLER_TESTPAT_EN
    .test_mode(test_mode),
`endif
    .bus(bus_b));

  int checks   = 0;
  int failures = 0;

  // model: window phase (-1 idle, 0..N-1 measuring, N publish), high-cycle totals, delayed samples
  int         scl [2] = '{1, 2};
  int         ph  [2];
  int         hi  [2][3];
  logic [2:0] hist[2][SYNC];
  int         e_s [2][3];
  int         e_v [2];
  int         e_seq[2];
  int         r_tp[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i] = -1; e_v[i] = 0; e_seq[i] = 0; r_tp[i] = 0;
      for (int c = 0; c < 3; c++) begin hi[i][c] = 0; e_s[i][c] = 0; end
      for (int k = 0; k < SYNC; k++) hist[i][k] = '0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic       en;
      logic [2:0] raw, seen;
      int         n;
      en   = (i == 0) ? bus_a.enable  : bus_b.enable;
      raw  = (i == 0) ? bus_a.pir_raw : bus_b.pir_raw;
      n    = 100 * scl[i];
      seen = hist[i][SYNC-1];
      for (int k = SYNC-1; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = raw;
      e_v[i] = 0;
      if (ph[i] < 0) begin
        if (en) begin ph[i] = 0; for (int c = 0; c < 3; c++) hi[i][c] = 0; end
      end else if (ph[i] < n) begin
        if (!en) ph[i] = -1;
        else begin
          for (int c = 0; c < 3; c++) hi[i][c] += int'(seen[c]);
          ph[i]++;
        end
      end else begin
        for (int c = 0; c < 3; c++) begin
          e_s[i][c] = hi[i][c] / scl[i];
          if (e_s[i][c] > 100) e_s[i][c] = 100;
          hi[i][c] = 0;
        end
`ifdef PIR_SAMPLER_TESTPAT_EN
        if (test_mode) begin
          e_s[i][0] = r_tp[i];
          e_s[i][1] = 100 - r_tp[i];
          e_s[i][2] = (r_tp[i] >= 50) ? 100 : 0;
        end
`endif
        r_tp[i]  = (r_tp[i] == 100) ? 0 : r_tp[i] + 10;
        e_v[i]   = 1;
        e_seq[i] = (e_seq[i] + 1) % 256;
        ph[i]    = en ? 0 : -1;
      end
    end
  endtask

  function automatic logic [29:0] obs(int i);
    if (i == 0) return {bus_a.pir_sensor_1, bus_a.pir_sensor_2, bus_a.pir_sensor_3, bus_a.sample_valid, bus_a.sample_seq};
    return {bus_b.pir_sensor_1, bus_b.pir_sensor_2, bus_b.pir_sensor_3, bus_b.sample_valid, bus_b.sample_seq};
  endfunction

  function automatic logic [29:0] exp_vec(int i);
    return {7'(e_s[i][0]), 7'(e_s[i][1]), 7'(e_s[i][2]), 1'(e_v[i]), 8'(e_seq[i])};
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic test_reset();
    bus_a.enable = 0; bus_a.pir_raw = '0;
    bus_b.enable = 0; bus_b.pir_raw = '0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs(i) !== 30'd0) begin failures++; $display("FAIL reset_%0d got %h want %h", i, obs(i), 30'd0); end
    end
    repeat (3) cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_full_high();
    int pulse = -1;
    bus_a.pir_raw = 3'b001;
    repeat (4) cyc();
    bus_a.enable = 1;
    for (int i = 0; i <= 110; i++) begin
      cyc();
      checks++;
      if (obs(0) !== exp_vec(0)) begin failures++; $display("FAIL full_high t=%0d got %h want %h", i, obs(0), exp_vec(0)); end
      if (bus_a.sample_valid && pulse < 0) pulse = i;
    end
    checks++;
    if (pulse != 101) begin failures++; $display("FAIL full_high_latency got %0d want 101", pulse); end
    checks++;
    if (obs(0) !== {7'd100, 7'd0, 7'd0, 1'b0, 8'd1}) begin
      failures++; $display("FAIL full_high_values got %h want %h", obs(0), {7'd100, 7'd0, 7'd0, 1'b0, 8'd1});
    end
    bus_a.enable = 0;
    cyc();
  endtask

  task automatic test_duty_mix();
    logic tog = 1'b0;
    for (int i = 0; i < 4; i++) begin bus_a.pir_raw = {tog, 2'b00}; tog = ~tog; cyc(); end
    bus_a.pir_raw = {tog, 2'b00}; tog = ~tog;
    bus_a.enable = 1;
    for (int i = 0; i <= 205; i++) begin
      cyc();
      checks++;
      if (obs(0) !== exp_vec(0)) begin failures++; $display("FAIL duty_mix t=%0d got %h want %h", i, obs(0), exp_vec(0)); end
      if (i == 101) begin
        checks++;
        if (bus_a.sample_valid !== 1'b1 || bus_a.pir_sensor_2 !== 7'd50 || bus_a.pir_sensor_3 !== 7'd50) begin
          failures++; $display("FAIL duty_mix_50 got v=%b %0d %0d want v=1 50 50", bus_a.sample_valid, bus_a.pir_sensor_2, bus_a.pir_sensor_3);
        end
      end
      if (i == 202) begin
        checks++;
        if (obs(0) !== exp_vec(0) || bus_a.sample_valid !== 1'b1 || {bus_a.pir_sensor_1, bus_a.pir_sensor_2, bus_a.pir_sensor_3} !== 21'd0) begin
          failures++; $display("FAIL duty_mix_low got %h want all-zero pulse", obs(0));
        end
      end
      bus_a.pir_raw = (i < 98) ? {tog, 1'(i >= 10 && i < 60), 1'b0} : 3'b000;
      tog = ~tog;
    end
    bus_a.enable = 0;
    cyc();
  endtask

  task automatic test_scale2();
    int p1 = -1, p2 = -1;
    bus_b.pir_raw = '0;
    bus_b.enable  = 1;
    for (int i = 0; i <= 420; i++) begin
      cyc();
      checks++;
      if (obs(1) !== exp_vec(1)) begin failures++; $display("FAIL scale2 t=%0d got %h want %h", i, obs(1), exp_vec(1)); end
      if (bus_b.sample_valid) begin
        if (p1 < 0) begin
          p1 = i;
          checks++;
          if (bus_b.pir_sensor_1 !== 7'd75) begin failures++; $display("FAIL scale2_duty got %0d want 75", bus_b.pir_sensor_1); end
        end else if (p2 < 0) p2 = i;
      end
      bus_b.pir_raw = {2'b00, 1'(i >= 5 && i < 156)};
    end
    checks++;
    if (p1 != 201) begin failures++; $display("FAIL scale2_latency got %0d want 201", p1); end
    checks++;
    if (p2 - p1 != 201) begin failures++; $display("FAIL scale2_period got %0d want 201", p2 - p1); end
    bus_b.enable = 0;
    cyc();
  endtask

  task automatic test_abort();
    logic [29:0] held;
    int pulse = -1;
    bus_a.enable = 1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      checks++;
      if (obs(0) !== exp_vec(0)) begin failures++; $display("FAIL abort_run t=%0d got %h want %h", i, obs(0), exp_vec(0)); end
      bus_a.pir_raw = 3'($urandom);
    end
    held = exp_vec(0);
    bus_a.enable = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if (obs(0) !== held) begin failures++; $display("FAIL abort_hold t=%0d got %h want %h", i, obs(0), held); end
    end
    bus_a.enable = 1;
    for (int i = 0; i <= 110; i++) begin
      cyc();
      checks++;
      if (obs(0) !== exp_vec(0)) begin failures++; $display("FAIL abort_resume t=%0d got %h want %h", i, obs(0), exp_vec(0)); end
      if (bus_a.sample_valid && pulse < 0) pulse = i;
      bus_a.pir_raw = 3'($urandom);
    end
    checks++;
    if (pulse != 101) begin failures++; $display("FAIL abort_latency got %0d want 101", pulse); end
    bus_a.enable = 0;
    cyc();
  endtask

  task automatic test_reset_mid();
    int pulse = -1;
    bus_a.pir_raw = 3'b111;
    bus_a.enable  = 1;
    repeat (50) cyc();
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs(0) !== 30'd0) begin failures++; $display("FAIL reset_mid got %h want %h", obs(0), 30'd0); end
    repeat (2) cyc();
    rst_n = 1'b1;
    for (int i = 0; i <= 110; i++) begin
      cyc();
      checks++;
      if (obs(0) !== exp_vec(0)) begin failures++; $display("FAIL reset_resume t=%0d got %h want %h", i, obs(0), exp_vec(0)); end
      if (bus_a.sample_valid && pulse < 0) pulse = i;
    end
    checks++;
    if (pulse != 101) begin failures++; $display("FAIL reset_resume_latency got %0d want 101", pulse); end
    bus_a.enable = 0;
    cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 2) bus_a.enable = ~bus_a.enable;
      if ($urandom_range(0, 99) < 2) bus_b.enable = ~bus_b.enable;
      bus_a.pir_raw = 3'($urandom);
      bus_b.pir_raw = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom);
      cyc();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs(k) !== exp_vec(k)) begin failures++; $display("FAIL random_%0d t=%0d got %h want %h", k, i, obs(k), exp_vec(k)); end
      end
    end
    bus_a.enable = 0; bus_b.enable = 0;
    cyc();
  endtask

`ifdef PIR_SAMPLER_TESTPAT_EN
  task automatic test_testpat();
    int n = 0;
    logic [20:0] want;
    bus_a.enable = 0; bus_b.enable = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    cyc();
    rst_n = 1'b1;
    test_mode = 1'b1;
    bus_a.enable = 1;
    for (int i = 0; i < 1400 && n < 12; i++) begin
      cyc();
      checks++;
      if (obs(0) !== exp_vec(0)) begin failures++; $display("FAIL testpat t=%0d got %h want %h", i, obs(0), exp_vec(0)); end
      if (bus_a.sample_valid) begin
        n++;
        case (n)
          1: want = {7'd0, 7'd100, 7'd0};
          2: want = {7'd10, 7'd90, 7'd0};
          3: want = {7'd20, 7'd80, 7'd0};
          6: want = {7'd50, 7'd50, 7'd100};
          12: want = {7'd0, 7'd100, 7'd0};
          default: want = {bus_a.pir_sensor_1, bus_a.pir_sensor_2, bus_a.pir_sensor_3};
        endcase
        if (n inside {1, 2, 3, 6, 12}) begin
          checks++;
          if ({bus_a.pir_sensor_1, bus_a.pir_sensor_2, bus_a.pir_sensor_3} !== want) begin
            failures++; $display("FAIL testpat_pub%0d got %h want %h", n, {bus_a.pir_sensor_1, bus_a.pir_sensor_2, bus_a.pir_sensor_3}, want);
          end
        end
      end
    end
    checks++;
    if (n != 12) begin failures++; $display("FAIL testpat_count got %0d want 12", n); end
    bus_a.enable = 0;
    test_mode = 1'b0;
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_full_high();
    test_duty_mix();
    test_scale2();
    test_abort();
    test_reset_mid();
    test_random();
`ifdef PIR_SAMPLER_TESTPAT_EN
    test_testpat();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
